// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared types and helpers for the double frame buffer
package fb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        CLEAR
    } fb_state_t;

    function automatic int fb_addr_w(input int h, input int v);
        return $clog2(h * v);
    endfunction

endpackage

// File: rtl/fb_bank.sv
// rtl/fb_bank.sv - simple dual-port pixel RAM, one write port and one registered read port
module fb_bank #(
    parameter int DEPTH = 16,
    parameter int A_W   = 4,
    parameter int PIX_W = 2
) (
    input  logic             clk,
    input  logic             we,
    input  logic [A_W-1:0]   waddr,
    input  logic [PIX_W-1:0] wdata,
    input  logic [A_W-1:0]   raddr,
    output logic [PIX_W-1:0] rdata
);

    logic [PIX_W-1:0] mem_q [DEPTH];
    logic [PIX_W-1:0] rdata_q;

    // Contents are intentionally not reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/double_frame_buffer.sv
// rtl/double_frame_buffer.sv - two-bank tear-free frame buffer with vblank swap and optional clear
module double_frame_buffer
    import fb_pkg::*;
#(
    parameter int                H_RES     = 160,
    parameter int                V_RES     = 144,
    parameter int                PIX_W     = 2,
    parameter int                CLEAR_EN  = 1,
    parameter logic [PIX_W-1:0]  CLEAR_VAL = '0,
    localparam int               X_W       = $clog2(H_RES),
    localparam int               Y_W       = $clog2(V_RES),
    localparam int               DEPTH     = H_RES * V_RES,
    localparam int               A_W       = fb_addr_w(H_RES, V_RES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [X_W-1:0]   wr_x,
    input  logic [Y_W-1:0]   wr_y,
    input  logic [PIX_W-1:0] wr_data,
    input  logic             frame_done,
    output logic             wr_ready,
    input  logic [X_W-1:0]   rd_x,
    input  logic [Y_W-1:0]   rd_y,
    input  logic             rd_vblank,
    output logic [PIX_W-1:0] rd_data,
    output logic             front_sel,
    output logic             swap_pending,
    output logic             clear_busy,
    output logic             frame_drop
);

    localparam logic [X_W:0]   H_LIM    = H_RES[X_W:0];
    localparam logic [Y_W:0]   V_LIM    = V_RES[Y_W:0];
    localparam logic [A_W-1:0] CLR_LAST = A_W'(DEPTH - 1);

    fb_state_t      state_q, state_d;
    logic           front_sel_q, front_sel_d;
    logic [A_W-1:0] clr_cnt_q, clr_cnt_d;
    logic           wr_ready_q, wr_ready_d;
    logic           swap_pending_q, swap_pending_d;
    logic           clear_busy_q, clear_busy_d;
    logic           frame_drop_q, frame_drop_d;
    logic           rd_sel_q, rd_sel_d;
    logic           rd_oor_q, rd_oor_d;
    logic           rd_vld_q, rd_vld_d;

    logic             wr_in_range, rd_in_range, wr_hit, clr_we;
    logic [A_W-1:0]   wr_addr, rd_addr, bank_waddr;
    logic [PIX_W-1:0] bank_wdata, bank0_rdata, bank1_rdata;
    logic             bank_we, bank0_we, bank1_we;

    assign wr_in_range = ({1'b0, wr_x} < H_LIM) && ({1'b0, wr_y} < V_LIM);
    assign rd_in_range = ({1'b0, rd_x} < H_LIM) && ({1'b0, rd_y} < V_LIM);
    assign wr_addr     = A_W'(wr_y) * A_W'(H_RES) + A_W'(wr_x);
    assign rd_addr     = A_W'(rd_y) * A_W'(H_RES) + A_W'(rd_x);

    // Writer and clear engine both target the back bank; they are never active together.
    assign wr_hit     = wr_en && wr_ready_q && wr_in_range;
    assign clr_we     = (state_q == CLEAR);
    assign bank_we    = wr_hit || clr_we;
    assign bank_waddr = clr_we ? clr_cnt_q : wr_addr;
    assign bank_wdata = clr_we ? CLEAR_VAL : wr_data;
    assign bank0_we   = bank_we && front_sel_q;
    assign bank1_we   = bank_we && !front_sel_q;

    always_comb begin
        state_d      = state_q;
        front_sel_d  = front_sel_q;
        clr_cnt_d    = clr_cnt_q;
        frame_drop_d = frame_done && (state_q != IDLE);
        rd_sel_d     = front_sel_q;
        rd_oor_d     = !rd_in_range;
        rd_vld_d     = 1'b1;
        unique case (state_q)
            IDLE: begin
                if (frame_done) begin
                    state_d = PEND;
                end
            end
            PEND: begin
                if (rd_vblank) begin
                    front_sel_d = !front_sel_q;
                    state_d     = (CLEAR_EN != 0) ? CLEAR : IDLE;
                end
            end
            CLEAR: begin
                if (clr_cnt_q == CLR_LAST) begin
                    clr_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + A_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        wr_ready_d     = (state_d == IDLE);
        swap_pending_d = (state_d == PEND);
        clear_busy_d   = (state_d == CLEAR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            front_sel_q    <= 1'b0;
            clr_cnt_q      <= '0;
            wr_ready_q     <= 1'b1;
            swap_pending_q <= 1'b0;
            clear_busy_q   <= 1'b0;
            frame_drop_q   <= 1'b0;
            rd_sel_q       <= 1'b0;
            rd_oor_q       <= 1'b0;
            rd_vld_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            front_sel_q    <= front_sel_d;
            clr_cnt_q      <= clr_cnt_d;
            wr_ready_q     <= wr_ready_d;
            swap_pending_q <= swap_pending_d;
            clear_busy_q   <= clear_busy_d;
            frame_drop_q   <= frame_drop_d;
            rd_sel_q       <= rd_sel_d;
            rd_oor_q       <= rd_oor_d;
            rd_vld_q       <= rd_vld_d;
        end
    end

    fb_bank #(.DEPTH(DEPTH), .A_W(A_W), .PIX_W(PIX_W)) u_bank0 (
        .clk   (clk),
        .we    (bank0_we),
        .waddr (bank_waddr),
        .wdata (bank_wdata),
        .raddr (rd_addr),
        .rdata (bank0_rdata)
    );

    fb_bank #(.DEPTH(DEPTH), .A_W(A_W), .PIX_W(PIX_W)) u_bank1 (
        .clk   (clk),
        .we    (bank1_we),
        .waddr (bank_waddr),
        .wdata (bank_wdata),
        .raddr (rd_addr),
        .rdata (bank1_rdata)
    );

    // Read mux uses the bank select captured alongside the address, so a swap never splits a read.
    assign rd_data      = !rd_vld_q ? '0 :
                          rd_oor_q  ? CLEAR_VAL :
                          (rd_sel_q ? bank1_rdata : bank0_rdata);
    assign wr_ready     = wr_ready_q;
    assign front_sel    = front_sel_q;
    assign swap_pending = swap_pending_q;
    assign clear_busy   = clear_busy_q;
    assign frame_drop   = frame_drop_q;

endmodule

// File: tb/tb_double_frame_buffer.sv
// tb/tb_double_frame_buffer.sv - self-checking bench for double_frame_buffer
module tb_double_frame_buffer;

    localparam int AH = 160;
    localparam int AV = 144;
    localparam int AD = AH * AV;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_reset = 1'b1, a_wr_en = 1'b0, a_frame_done = 1'b0, a_rd_vblank = 1'b0;
    logic [7:0] a_wr_x = '0, a_wr_y = '0, a_rd_x = '0, a_rd_y = '0;
    logic [1:0] a_wr_data = '0, a_rd_data;
    logic       a_wr_ready, a_front_sel, a_swap_pending, a_clear_busy, a_frame_drop;

    logic       b_reset = 1'b1, b_wr_en = 1'b0, b_frame_done = 1'b0, b_rd_vblank = 1'b0;
    logic [2:0] b_wr_x = '0, b_rd_x = '0;
    logic [1:0] b_wr_y = '0, b_rd_y = '0;
    logic [3:0] b_wr_data = '0, b_rd_data;
    logic       b_wr_ready, b_front_sel, b_swap_pending, b_clear_busy, b_frame_drop;

    double_frame_buffer u_dut_a (
        .clk(clk), .reset(a_reset), .wr_en(a_wr_en), .wr_x(a_wr_x), .wr_y(a_wr_y),
        .wr_data(a_wr_data), .frame_done(a_frame_done), .wr_ready(a_wr_ready),
        .rd_x(a_rd_x), .rd_y(a_rd_y), .rd_vblank(a_rd_vblank), .rd_data(a_rd_data),
        .front_sel(a_front_sel), .swap_pending(a_swap_pending), .clear_busy(a_clear_busy),
        .frame_drop(a_frame_drop)
    );

    double_frame_buffer #(.H_RES(8), .V_RES(4), .PIX_W(4), .CLEAR_EN(0), .CLEAR_VAL(4'h0)) u_dut_b (
        .clk(clk), .reset(b_reset), .wr_en(b_wr_en), .wr_x(b_wr_x), .wr_y(b_wr_y),
        .wr_data(b_wr_data), .frame_done(b_frame_done), .wr_ready(b_wr_ready),
        .rd_x(b_rd_x), .rd_y(b_rd_y), .rd_vblank(b_rd_vblank), .rd_data(b_rd_data),
        .front_sel(b_front_sel), .swap_pending(b_swap_pending), .clear_busy(b_clear_busy),
        .frame_drop(b_frame_drop)
    );

    int checks = 0;
    int errors = 0;
    int drops  = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model of instance A: phase 0 = accepting writes, 1 = waiting for vblank, 2 = clearing
    logic [1:0] m_mem [2][AD];
    bit         m_vld [2][AD];
    int         m_phase = 0, m_left = 0;
    bit         m_front = 1'b0, m_drop = 1'b0, m_rd_known = 1'b1;
    logic [1:0] m_rd = '0;

    always @(posedge clk) begin
        if (a_reset) begin
            m_phase <= 0; m_front <= 1'b0; m_rd <= '0; m_rd_known <= 1'b1;
            m_drop <= 1'b0; m_left <= 0;
        end else begin
            if (int'(a_rd_x) < AH && int'(a_rd_y) < AV) begin
                m_rd       <= m_mem[m_front][int'(a_rd_y) * AH + int'(a_rd_x)];
                m_rd_known <= m_vld[m_front][int'(a_rd_y) * AH + int'(a_rd_x)];
            end else begin
                m_rd <= '0; m_rd_known <= 1'b1;
            end
            m_drop <= a_frame_done && (m_phase != 0);
            if (m_phase == 0) begin
                if (a_wr_en && int'(a_wr_x) < AH && int'(a_wr_y) < AV) begin
                    m_mem[!m_front][int'(a_wr_y) * AH + int'(a_wr_x)] <= a_wr_data;
                    m_vld[!m_front][int'(a_wr_y) * AH + int'(a_wr_x)] <= 1'b1;
                end
                if (a_frame_done) m_phase <= 1;
            end else if (m_phase == 1) begin
                if (a_rd_vblank) begin
                    m_front <= !m_front; m_phase <= 2; m_left <= AD;
                end
            end else begin
                m_mem[!m_front][AD - m_left] <= 2'b00;
                m_vld[!m_front][AD - m_left] <= 1'b1;
                m_left <= m_left - 1;
                if (m_left == 1) m_phase <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("a_wr_ready", a_wr_ready, m_phase == 0);
            check("a_swap_pending", a_swap_pending, m_phase == 1);
            check("a_clear_busy", a_clear_busy, m_phase == 2);
            check("a_front_sel", a_front_sel, m_front);
            check("a_frame_drop", a_frame_drop, m_drop);
            if (m_rd_known) check("a_rd_data", a_rd_data, m_rd);
            if (a_frame_drop) drops++;
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog expired actual=running expected=finished");
        $fatal(1);
    end

    task automatic a_wr(input int x, input int y, input int d);
        a_wr_en = 1'b1; a_wr_x = 8'(x); a_wr_y = 8'(y); a_wr_data = 2'(d);
        @(negedge clk);
        a_wr_en = 1'b0;
    endtask

    task automatic b_wr(input int x, input int y, input int d);
        b_wr_en = 1'b1; b_wr_x = 3'(x); b_wr_y = 2'(y); b_wr_data = 4'(d);
        @(negedge clk);
        b_wr_en = 1'b0;
    endtask

    initial begin
        int cnt;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_front", a_front_sel, 0);
        check("rst_wr_ready", a_wr_ready, 1);
        check("rst_rd_data", a_rd_data, 0);
        check("rst_pending", a_swap_pending, 0);
        check("rst_clear", a_clear_busy, 0);
        check("b_rst_wr_ready", b_wr_ready, 1);
        a_reset = 1'b0; b_reset = 1'b0;

        a_wr(3, 2, 3);
        a_wr(0, 1, 2);
        a_wr(160, 0, 1);
        a_rd_x = 8'd0; a_rd_y = 8'd144;
        @(negedge clk);
        check("oor_read", a_rd_data, 0);
        a_rd_y = 8'd0;

        // write on the frame_done cycle must still land
        a_wr_en = 1'b1; a_wr_x = 8'd4; a_wr_y = 8'd2; a_wr_data = 2'd1; a_frame_done = 1'b1;
        @(negedge clk);
        a_frame_done = 1'b0;
        a_wr_x = 8'd3; a_wr_data = 2'd1;
        for (int i = 0; i < 10; i++) begin
            a_frame_done = (i == 3);
            @(negedge clk);
            a_wr_en = 1'b0;
        end
        a_frame_done = 1'b0;
        check("pend_pending", a_swap_pending, 1);
        check("pend_front", a_front_sel, 0);
        check("pend_wr_ready", a_wr_ready, 0);
        check("drop_in_pend", drops, 1);

        a_rd_x = 8'd3; a_rd_y = 8'd2; a_rd_vblank = 1'b1;
        @(negedge clk);
        a_rd_vblank = 1'b0;
        check("swap_front", a_front_sel, 1);
        check("swap_clear_busy", a_clear_busy, 1);
        @(negedge clk);
        check("swap_rd_32", a_rd_data, 3);
        cnt = 2;
        while (cnt < 30000) begin
            a_frame_done = (cnt == 100);
            a_rd_x = 8'($urandom_range(0, 170));
            a_rd_y = 8'($urandom_range(0, 150));
            @(negedge clk);
            if (!a_clear_busy) break;
            cnt++;
        end
        a_frame_done = 1'b0;
        check("clear_len", cnt, 23040);
        check("clear_done_ready", a_wr_ready, 1);
        check("drop_in_clear", drops, 2);
        a_rd_x = 8'd0; a_rd_y = 8'd1;
        @(negedge clk);
        check("oor_write_dropped", a_rd_data, 2);
        a_rd_x = 8'd4; a_rd_y = 8'd2;
        @(negedge clk);
        check("write_with_done", a_rd_data, 1);
        a_rd_x = 8'd3;

        a_frame_done = 1'b1;
        @(negedge clk);
        a_frame_done = 1'b0; a_rd_vblank = 1'b1;
        @(negedge clk);
        a_rd_vblank = 1'b0;
        check("swap2_front", a_front_sel, 0);
        check("swap2_old_front", a_rd_data, 3);
        @(negedge clk);
        check("bank0_cleared", a_rd_data, 0);
        cnt = 0;
        while (a_clear_busy && cnt < 30000) begin
            @(negedge clk);
            cnt++;
        end
        check("clear2_ended", a_clear_busy, 0);

        // frame_done together with vblank only arms the swap
        a_frame_done = 1'b1; a_rd_vblank = 1'b1;
        @(negedge clk);
        check("no_early_swap", a_front_sel, 0);
        check("early_pending", a_swap_pending, 1);
        a_frame_done = 1'b0;
        @(negedge clk);
        a_rd_vblank = 1'b0;
        check("swap3_front", a_front_sel, 1);
        cnt = 1;
        for (int i = 0; i < 40; i++) begin
            a_rd_x = 8'((i * 37) % AH); a_rd_y = 8'((i * 53) % AV);
            if (i == 0) begin a_rd_x = 8'd3; a_rd_y = 8'd2; end
            @(negedge clk);
            cnt++;
            check("bank1_cleared", a_rd_data, 0);
        end
        while (cnt < 501) begin
            @(negedge clk);
            cnt++;
        end
        check("mid_clear_busy", a_clear_busy, 1);
        a_reset = 1'b1;
        @(negedge clk);
        a_reset = 1'b0;
        check("abort_front", a_front_sel, 0);
        check("abort_clear", a_clear_busy, 0);
        check("abort_wr_ready", a_wr_ready, 1);
        check("abort_rd_data", a_rd_data, 0);

        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 8; x++)
                b_wr(x, y, (y * 8 + x + 3) % 16);
        b_frame_done = 1'b1;
        @(negedge clk);
        b_frame_done = 1'b0;
        check("b_pending", b_swap_pending, 1);
        check("b_wr_ready_pend", b_wr_ready, 0);
        b_rd_vblank = 1'b1;
        @(negedge clk);
        b_rd_vblank = 1'b0;
        check("b_front", b_front_sel, 1);
        check("b_no_clear", b_clear_busy, 0);
        check("b_idle_ready", b_wr_ready, 1);
        check("b_not_pending", b_swap_pending, 0);
        b_rd_x = 3'd1; b_rd_y = 2'd2;
        @(negedge clk);
        check("b_map_1_2", b_rd_data, 4'h4);
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 8; x++) begin
                b_rd_x = 3'(x); b_rd_y = 2'(y);
                @(negedge clk);
                check("b_map", b_rd_data, 32'((y * 8 + x + 3) % 16));
            end
        check("b_no_drop", b_frame_drop, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
